// File: rtl/song_sequencer.sv
`timescale 1ns/1ps
// song_sequencer: walks one song region of a synchronous note ROM and hands each note to the
// note player over a valid/ready handshake. Define SONG_SEQUENCER_LOOP_EN to enable looping.
module song_sequencer #(
  parameter int SONG_W  = 2,
  parameter int OFS_W   = 7,
  parameter int DATA_W  = 16,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      play,
  input  logic                      pause,
  input  logic                      loop,
  input  logic [SONG_W-1:0]         song,
  input  logic                      note_done,
  input  logic                      note_ready,
  output logic [SONG_W+OFS_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [DATA_W-1:0]         out_data,
  output logic                      new_note,
  output logic [OFS_W-1:0]          note_index,
  output logic                      song_done,
  output logic                      loop_wrap,
  output logic                      busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0]       LAT_LAST = 2'(ROM_LAT);
  localparam logic [OFS_W-1:0] OFS_LAST = '1;

  state_t              state_q, state_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [OFS_W-1:0]    offset_q, offset_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [OFS_W-1:0]    note_index_q, note_index_d;
  logic                end_pend_q, end_pend_d;
  logic                done_pend_q, done_pend_d;
  logic                loop_wrap_q, loop_wrap_d;
  logic                accept;
  logic                end_song;
  logic                loop_active;

`ifdef SONG_SEQUENCER_LOOP_EN
  assign loop_active = loop;
`else
  logic loop_unused;
  assign loop_unused = loop;
  assign loop_active = 1'b0;
`endif

  // Stop also withdraws the offer immediately so a dropped note can never be accepted.
  assign new_note   = (state_q == S_ISSUE) && play && !pause;
  assign accept     = new_note && note_ready;
  assign rom_addr   = {song_q, offset_q};
  assign out_data   = out_data_q;
  assign note_index = note_index_q;
  assign song_done  = (state_q == S_DONE);
  assign loop_wrap  = loop_wrap_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d      = state_q;
    song_d       = song_q;
    offset_d     = offset_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    note_index_d = note_index_q;
    end_pend_d   = end_pend_q;
    done_pend_d  = done_pend_q;
    loop_wrap_d  = 1'b0;
    end_song     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (play && !pause) begin
          state_d     = S_FETCH;
          song_d      = song;
          offset_d    = '0;
          cnt_d       = '0;
          end_pend_d  = 1'b0;
          done_pend_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (!play) begin
          state_d = S_IDLE;
        end else if (!pause) begin
          if (cnt_q == LAT_LAST) begin
            cnt_d      = '0;
            out_data_d = rom_data;
            if (rom_data == '0) begin
              end_song = 1'b1;
            end else begin
              state_d = S_ISSUE;
            end
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_ISSUE: begin
        if (!play) begin
          state_d = S_IDLE;
        end else if (accept) begin
          note_index_d = offset_q;
          // The last slot of a region never wraps the address; it arms the end-of-song path.
          if (offset_q == OFS_LAST) begin
            end_pend_d = 1'b1;
          end else begin
            offset_d = offset_q + 1'b1;
          end
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!play) begin
          state_d = S_IDLE;
        end else if (pause) begin
          if (note_done) begin
            done_pend_d = 1'b1;
          end
        end else if (note_done || done_pend_q) begin
          done_pend_d = 1'b0;
          if (end_pend_q) begin
            end_song = 1'b1;
          end else begin
            state_d = S_FETCH;
            cnt_d   = '0;
          end
        end
      end
      S_DONE: begin
        if (!play && !pause) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (end_song) begin
      end_pend_d = 1'b0;
      if (loop_active) begin
        offset_d    = '0;
        cnt_d       = '0;
        loop_wrap_d = 1'b1;
        state_d     = S_FETCH;
      end else begin
        state_d = S_DONE;
      end
    end

    if (state_d == S_IDLE) begin
      done_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      song_q       <= '0;
      offset_q     <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      note_index_q <= '0;
      end_pend_q   <= 1'b0;
      done_pend_q  <= 1'b0;
      loop_wrap_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      song_q       <= song_d;
      offset_q     <= offset_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      note_index_q <= note_index_d;
      end_pend_q   <= end_pend_d;
      done_pend_q  <= done_pend_d;
      loop_wrap_q  <= loop_wrap_d;
    end
  end

endmodule
